// File: rtl/tdc_ctrl_pkg.sv
// Shared types and widths for the ring-oscillator TDC sequencer and readout.
// Used by tdc_ctrl and tdc_phase_dec.
package tdc_ctrl_pkg;

    localparam int COARSE_W = 7;
    localparam int FINE_W   = 5;
    localparam int WORD_W   = 12;
    localparam int NPH      = 16;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_PWRUP = 3'd1,
        ST_INJ   = 3'd2,
        ST_PRIME = 3'd3,
        ST_RUN   = 3'd4
    } tdc_state_t;

    function automatic logic [4:0] popcount16(input logic [NPH-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < NPH; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tdc_phase_dec.sv
// Combinational decode of the 16 sampled RO phases into a 5-bit fine code,
// with a validity flag that rejects bubbled (non-thermometer-ring) patterns.
module tdc_phase_dec
    import tdc_ctrl_pkg::*;
(
    input  logic [NPH-1:0]    phase,
    output logic [FINE_W-1:0] fine,
    output logic              valid
);

    logic [NPH-1:0] x;
    logic [NPH-1:0] x_rot;
    logic [4:0]     p;
    logic [4:0]     t;

    always_comb begin
        x     = phase ^ {NPH{phase[0]}};
        // x_rot[i] = x[(i+1) % NPH], so x ^ x_rot marks every ring transition
        x_rot = {x[0], x[NPH-1:1]};
        p     = popcount16(phase);
        t     = popcount16(x ^ x_rot);
        fine  = phase[0] ? 5'(6'd32 - {1'b0, p}) : p;
        valid = (t == 5'd0) || (t == 5'd2);
    end

endmodule

// File: rtl/tdc_ctrl.sv
// TDC sequencer (power-up, injection lock, prime) and readout producing word deltas.
// Optional TDC_CTRL_AVG_EN averages deltas over 2^AVG_LOG2 valid samples.
module tdc_ctrl
    import tdc_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int LOCK_CYC   = 32,
    parameter int ERR_MAX    = 4
`ifdef TDC_CTRL_AVG_EN
   ,parameter int AVG_LOG2   = 2
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [2:0]          ctr_freq_cfg,
    input  logic [COARSE_W-1:0] ripple_count,
    input  logic [NPH-1:0]      phase,
    output logic                tdc_pd,
    output logic                tdc_pd_inj,
    output logic [2:0]          tdc_ctr_freq,
    output logic [WORD_W-1:0]   tdc_word,
    output logic [WORD_W-1:0]   tdc_delta,
    output logic                tdc_valid,
    output logic                bubble_err,
    output logic                busy,
    output logic [2:0]          state_o
);

    // state  | meaning
    // OFF    | TDC and injection powered down, waiting for en
    // PWRUP  | RO free-running, settle timer counting
    // INJ    | injection enabled, lock timer counting
    // PRIME  | waiting for first clean pattern to seed prev_word
    // RUN    | producing words and deltas every valid sample

    localparam int TMR_MAX = (SETTLE_CYC > LOCK_CYC) ? SETTLE_CYC : LOCK_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam int ERR_W   = $clog2(ERR_MAX + 1);

    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] LOCK_LD   = TMR_W'(LOCK_CYC - 1);
    localparam logic [ERR_W-1:0] ERR_LAST  = ERR_W'(ERR_MAX - 1);

    logic [COARSE_W-1:0] cap_rc;
    logic [NPH-1:0]      cap_ph;
    logic [FINE_W-1:0]   fine;
    logic                ph_ok;
    logic [WORD_W-1:0]   word_now;
    logic [WORD_W-1:0]   delta_now;
    logic [WORD_W-1:0]   prev_word;
    tdc_state_t          state;
    logic [TMR_W-1:0]    tmr;
    logic [ERR_W-1:0]    err_cnt;

`ifdef TDC_CTRL_AVG_EN
    localparam int ACC_W = WORD_W + AVG_LOG2;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [AVG_LOG2-1:0] avg_cnt;

    assign acc_sum = acc + {{AVG_LOG2{1'b0}}, delta_now};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_rc <= '0;
            cap_ph <= '0;
        end else begin
            cap_rc <= ripple_count;
            cap_ph <= phase;
        end
    end

    tdc_phase_dec u_dec (
        .phase (cap_ph),
        .fine  (fine),
        .valid (ph_ok)
    );

    assign word_now  = {cap_rc, fine};
    assign delta_now = word_now - prev_word;
    assign state_o   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_OFF;
            tdc_pd       <= 1'b1;
            tdc_pd_inj   <= 1'b1;
            tdc_ctr_freq <= '0;
            tdc_word     <= '0;
            tdc_delta    <= '0;
            tdc_valid    <= 1'b0;
            bubble_err   <= 1'b0;
            busy         <= 1'b0;
            prev_word    <= '0;
            tmr          <= '0;
            err_cnt      <= '0;
`ifdef TDC_CTRL_AVG_EN
            acc          <= '0;
            avg_cnt      <= '0;
`endif
        end else begin
            tdc_valid  <= 1'b0;
            bubble_err <= 1'b0;
            if (!en) begin
                // dropping en overrides everything, including an error restart
                state      <= ST_OFF;
                tdc_pd     <= 1'b1;
                tdc_pd_inj <= 1'b1;
                busy       <= 1'b0;
                tmr        <= '0;
                err_cnt    <= '0;
`ifdef TDC_CTRL_AVG_EN
                acc        <= '0;
                avg_cnt    <= '0;
`endif
            end else begin
                case (state)
                    ST_OFF: begin
                        state        <= ST_PWRUP;
                        tdc_ctr_freq <= ctr_freq_cfg;
                        tdc_pd       <= 1'b0;
                        tdc_pd_inj   <= 1'b1;
                        busy         <= 1'b1;
                        tmr          <= SETTLE_LD;
                        err_cnt      <= '0;
                    end
                    ST_PWRUP: begin
                        if (tmr == '0) begin
                            state      <= ST_INJ;
                            tdc_pd_inj <= 1'b0;
                            tmr        <= LOCK_LD;
                        end else begin
                            tmr <= tmr - TMR_W'(1);
                        end
                    end
                    ST_INJ: begin
                        if (tmr == '0) begin
                            state <= ST_PRIME;
                        end else begin
                            tmr <= tmr - TMR_W'(1);
                        end
                    end
                    ST_PRIME: begin
                        if (ph_ok) begin
                            prev_word <= word_now;
                            state     <= ST_RUN;
                            busy      <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (ph_ok) begin
                            tdc_word  <= word_now;
                            prev_word <= word_now;
                            err_cnt   <= '0;
`ifdef TDC_CTRL_AVG_EN
                            if (avg_cnt == '1) begin
                                tdc_delta <= acc_sum[AVG_LOG2 +: WORD_W];
                                tdc_valid <= 1'b1;
                                acc       <= '0;
                                avg_cnt   <= '0;
                            end else begin
                                acc     <= acc_sum;
                                avg_cnt <= avg_cnt + AVG_LOG2'(1);
                            end
`else
                            tdc_delta <= delta_now;
                            tdc_valid <= 1'b1;
`endif
                        end else begin
                            bubble_err <= 1'b1;
                            if (err_cnt == ERR_LAST) begin
                                state      <= ST_PWRUP;
                                tdc_pd_inj <= 1'b1;
                                busy       <= 1'b1;
                                tmr        <= SETTLE_LD;
                                err_cnt    <= '0;
`ifdef TDC_CTRL_AVG_EN
                                acc        <= '0;
                                avg_cnt    <= '0;
`endif
                            end else begin
                                err_cnt <= err_cnt + ERR_W'(1);
                            end
                        end
                    end
                    default: begin
                        state      <= ST_OFF;
                        tdc_pd     <= 1'b1;
                        tdc_pd_inj <= 1'b1;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdc_ctrl.sv
// Self-checking bench for tdc_ctrl: directed sequences plus randomized phases/coarse
// counts, compared every cycle against a timeline-based reference model.
`timescale 1ns/1ps
module tb_tdc_ctrl;

    localparam int SETTLE = 16;
    localparam int LOCK   = 32;
    localparam int ERRM   = 4;
    localparam int NAVG   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  ctr_freq_cfg;
    logic [6:0]  ripple_count;
    logic [15:0] phase;
    logic        tdc_pd;
    logic        tdc_pd_inj;
    logic [2:0]  tdc_ctr_freq;
    logic [11:0] tdc_word;
    logic [11:0] tdc_delta;
    logic        tdc_valid;
    logic        bubble_err;
    logic        busy;
    logic [2:0]  state_o;

    tdc_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .ctr_freq_cfg (ctr_freq_cfg),
        .ripple_count (ripple_count),
        .phase        (phase),
        .tdc_pd       (tdc_pd),
        .tdc_pd_inj   (tdc_pd_inj),
        .tdc_ctr_freq (tdc_ctr_freq),
        .tdc_word     (tdc_word),
        .tdc_delta    (tdc_delta),
        .tdc_valid    (tdc_valid),
        .bubble_err   (bubble_err),
        .busy         (busy),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sequence position is time elapsed since the power-up began.
    bit          m_on, m_primed;
    int          m_t, m_errs, m_acc, m_n;
    logic [6:0]  m_cap_rc;
    logic [15:0] m_cap_ph;
    logic [11:0] m_prev, m_word, m_delta;
    logic [2:0]  m_freq;
    bit          m_valid, m_bub;

    function automatic int ref_fine(input logic [15:0] ph);
        int p = $countones(ph);
        return ph[0] ? (32 - p) % 32 : p;
    endfunction

    function automatic bit ref_ok(input logic [15:0] ph);
        int t = 0;
        for (int i = 0; i < 16; i++) if (ph[i] != ph[(i + 1) % 16]) t++;
        return (t == 0) || (t == 2);
    endfunction

    function automatic logic [15:0] ring_pat(input int s, input int l);
        logic [15:0] v = '0;
        for (int i = 0; i < l; i++) v[(s + i) % 16] = 1'b1;
        return v;
    endfunction

    function automatic int exp_state();
        if (!m_on) return 0;
        if (m_t < SETTLE) return 1;
        if (m_t < SETTLE + LOCK) return 2;
        if (!m_primed) return 3;
        return 4;
    endfunction

    task automatic m_reset();
        m_on = 0; m_primed = 0; m_t = 0; m_errs = 0; m_acc = 0; m_n = 0;
        m_cap_rc = '0; m_cap_ph = '0; m_prev = '0; m_word = '0; m_delta = '0;
        m_freq = '0; m_valid = 0; m_bub = 0;
    endtask

    task automatic model_edge(input logic e, input logic [2:0] cfg,
                              input logic [6:0] rc, input logic [15:0] ph);
        logic [11:0] w, d;
        m_valid = 0;
        m_bub   = 0;
        if (!e) begin
            m_on = 0; m_acc = 0; m_n = 0;
        end else if (!m_on) begin
            m_on = 1; m_t = 0; m_primed = 0; m_errs = 0; m_freq = cfg;
        end else if (m_t < SETTLE + LOCK) begin
            m_t++;
        end else if (!m_primed) begin
            if (ref_ok(m_cap_ph)) begin
                m_prev   = {m_cap_rc, 5'(ref_fine(m_cap_ph))};
                m_primed = 1;
            end
        end else if (ref_ok(m_cap_ph)) begin
            w = {m_cap_rc, 5'(ref_fine(m_cap_ph))};
            d = w - m_prev;
`ifdef TDC_CTRL_AVG_EN
            m_acc += int'(d);
            m_n++;
            if (m_n == NAVG) begin
                m_delta = 12'(m_acc / NAVG);
                m_valid = 1;
                m_acc = 0;
                m_n = 0;
            end
`else
            m_delta = d;
            m_valid = 1;
`endif
            m_word = w; m_prev = w; m_errs = 0;
        end else begin
            m_bub = 1;
            m_errs++;
            if (m_errs == ERRM) begin
                m_t = 0; m_primed = 0; m_errs = 0; m_acc = 0; m_n = 0;
            end
        end
        m_cap_rc = rc;
        m_cap_ph = ph;
    endtask

    task automatic compare_all();
        check("tdc_pd", tdc_pd, !m_on);
        check("tdc_pd_inj", tdc_pd_inj, !(m_on && m_t >= SETTLE));
        check("tdc_ctr_freq", tdc_ctr_freq, m_freq);
        check("tdc_word", tdc_word, m_word);
        check("tdc_delta", tdc_delta, m_delta);
        check("tdc_valid", tdc_valid, m_valid);
        check("bubble_err", bubble_err, m_bub);
        check("busy", busy, m_on && !m_primed);
        check("state_o", state_o, exp_state());
    endtask

    task automatic step(input logic e, input logic [2:0] cfg,
                        input logic [6:0] rc, input logic [15:0] ph);
        en = e; ctr_freq_cfg = cfg; ripple_count = rc; phase = ph;
        @(posedge clk);
        model_edge(e, cfg, rc, ph);
        #1;
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pd"}, tdc_pd, 1);
        check({tag, "_pd_inj"}, tdc_pd_inj, 1);
        check({tag, "_freq"}, tdc_ctr_freq, 0);
        check({tag, "_word"}, tdc_word, 0);
        check({tag, "_delta"}, tdc_delta, 0);
        check({tag, "_valid"}, tdc_valid, 0);
        check({tag, "_bub"}, bubble_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_state"}, state_o, 0);
    endtask

    logic [6:0]  rc;
    logic [15:0] ph;
    int          n_bub, burst;
    bit          e_r;

    initial begin
        rst_n = 1'b0; en = 1'b0; ctr_freq_cfg = '0; ripple_count = '0; phase = '0;
        m_reset();
        #12;
        check_reset_values("rst");
        rst_n = 1'b1;
        rc = '0;
        step(0, 3'd2, rc, 16'h0000);
        step(0, 3'd2, rc, 16'h0000);

        // Power-up with trim 5, then run with coarse +10 and fine 24 (wraps 120 -> 2).
        for (int i = 0; i < 90; i++) begin
            step(1, 3'd5, rc, 16'h00FF);
            if (tdc_valid) check("delta_320", tdc_delta, 320);
            rc = rc + 7'd10;
        end
        check("trim_latched", tdc_ctr_freq, 5);
        check("fine_24", tdc_word[4:0], 24);
        check("run_state", state_o, 4);

        // Four bubbled samples force a restart through PWRUP.
        n_bub = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 3'd1, rc, (i < 4) ? 16'h0F0F : 16'h00FF);
            if (bubble_err) n_bub++;
            rc = rc + 7'd10;
        end
        check("bubble_count", n_bub, 4);
        check("err_restart", state_o, 1);
        check("word_held", tdc_word, m_word);

        // Drop en during INJ.
        for (int i = 0; i < 20; i++) begin
            step(1, 3'd1, rc, 16'h00FF);
            rc = rc + 7'd3;
        end
        check("in_inj", state_o, 2);
        step(0, 3'd1, rc, 16'h00FF);
        check("inj_off_state", state_o, 0);
        check("inj_off_pd", tdc_pd, 1);
        check("inj_off_pd_inj", tdc_pd_inj, 1);

        // Randomized run: mostly clean ring patterns, occasional bursts and en drops.
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            e_r = ($urandom_range(0, 299) != 0);
            if (burst > 0) begin
                ph = ($urandom_range(0, 1) != 0) ? 16'h0F0F : 16'(($urandom & 32'hFFFF) | 32'h0101);
                burst--;
            end else if ($urandom_range(0, 99) < 3) begin
                burst = $urandom_range(2, 6);
                ph = 16'h0F0F;
            end else if ($urandom_range(0, 99) < 10) begin
                ph = 16'($urandom);
            end else begin
                ph = ring_pat($urandom_range(0, 15), $urandom_range(0, 16));
            end
            step(e_r, 3'($urandom), rc, ph);
            rc = rc + 7'($urandom_range(0, 40));
        end

        // Bring it back to RUN, then pulse reset mid-cycle.
        for (int i = 0; i < 200; i++) begin
            step(1, 3'd6, rc, 16'h07F0);
            rc = rc + 7'd7;
            if (state_o == 3'd4 && i > 5) break;
        end
        check("reach_run", state_o, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        m_reset();
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step(1, 3'd3, rc, ring_pat(i % 16, 5));
            rc = rc + 7'd9;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tdc_ctrl.md
Name: tdc_ctrl

Overview:
- Sequencer and readout controller for the ring-oscillator TDC.
- Drives the TDC control pins (pd, pd_inj, ctr_freq) through a power-up and injection-lock sequence.
- Registers the TDC outputs (ripple_count, phase), decodes the 16 sampled phases into a 5-bit fine code, and forms a 12-bit TDC word.
- Outputs per-reference-cycle word deltas to the ADPLL phase detector.

Parameters:
- SETTLE_CYC, 16, clk cycles in PWRUP with the RO free-running (pd_inj=1).
- LOCK_CYC, 32, clk cycles in INJ after injection is enabled, before samples count.
- ERR_MAX, 4, consecutive bubble errors that force a restart through PWRUP.
- AVG_LOG2, 2, log2 of samples averaged (used only with TDC_CTRL_AVG_EN).

Ports:
- clk  in  1  reference clock; same clock that samples the TDC.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  level; 1 = run the TDC, 0 = power it down.
- ctr_freq_cfg  in  3  RO frequency trim; latched on leaving OFF.
- ripple_count  in  7  TDC coarse count.
- phase  in  16  TDC sampled phases.
- tdc_pd  out  1  TDC power-down.
- tdc_pd_inj  out  1  injection power-down.
- tdc_ctr_freq  out  3  latched trim.
- tdc_word  out  12  {coarse[6:0], fine[4:0]}.
- tdc_delta  out  12  (tdc_word - previous tdc_word) mod 4096.
- tdc_valid  out  1  1-cycle strobe; tdc_word and tdc_delta are updated.
- bubble_err  out  1  1-cycle strobe; current phase pattern is invalid.
- busy  out  1  high in PWRUP, INJ and PRIME.
- state_o  out  3  current FSM state encoding.

Behaviour:
- Reset values: tdc_pd=1, tdc_pd_inj=1, tdc_ctr_freq=0, tdc_word=0, tdc_delta=0, tdc_valid=0, bubble_err=0, busy=0, state_o=OFF.
- Input capture:
  - ripple_count and phase are registered on every rising edge of clk.
  - The decode operates on the registered copy, so there is 1 cycle of input latency.
- Fine decode:
  - x = phase ^ {16{phase[0]}}; p = popcount(phase).
  - fine = phase[0] ? (32 - p) : p, taken as 5 bits, range 0..31.
  - Count ring transitions t = number of i in 0..15 with x[i] != x[(i+1)%16].
  - The pattern is valid iff t is 0 or 2.
- FSM states: OFF=0, PWRUP=1, INJ=2, PRIME=3, RUN=4.
  - OFF: tdc_pd=1, tdc_pd_inj=1. On en=1, latch ctr_freq_cfg and go to PWRUP.
  - PWRUP: tdc_pd=0, tdc_pd_inj=1. Count SETTLE_CYC cycles, then go to INJ.
  - INJ: tdc_pd_inj=0. Count LOCK_CYC cycles, then go to PRIME.
  - PRIME: on the first valid pattern, load prev_word and go to RUN, with no tdc_valid. An invalid pattern keeps the FSM in PRIME.
  - RUN, each cycle:
    - Valid pattern: update tdc_word, tdc_delta and prev_word; pulse tdc_valid; clear the error counter.
    - Invalid pattern: pulse bubble_err; hold tdc_word and tdc_delta; no tdc_valid; error counter +1.
    - Reaching ERR_MAX: go to PWRUP and clear the counters.
- en=0 in any state: go to OFF the next cycle, with tdc_pd=1 the same cycle the state changes. This takes priority over all other transitions.
- Output latency: tdc_valid asserts 2 cycles after the edge at which the TDC sampled, i.e. capture register plus output register.
- Wrap: delta is computed modulo 4096. A coarse wrap from 127 to 0 produces the correct positive delta.
- Simultaneous en=0 and ERR_MAX: go to OFF.
- Asynchronous reset mid-sequence: return immediately to the reset values listed above.

Optional Feature:
- TDC_CTRL_AVG_EN defined:
  - Deltas are accumulated over 2^AVG_LOG2 valid samples in a 12+AVG_LOG2-bit accumulator.
  - tdc_delta = accumulator >> AVG_LOG2, with tdc_valid pulsing once per block.
  - tdc_word still tracks the most recent sample.
  - Leaving RUN clears the accumulator.
- TDC_CTRL_AVG_EN undefined: one tdc_valid per valid sample, as specified above.

Decomposition:
- Package tdc_ctrl_pkg:
  - state enum tdc_state_t;
  - localparams COARSE_W=7, FINE_W=5, WORD_W=12, NPH=16.
- Sub-module tdc_phase_dec:
  - Combinational; input phase[15:0].
  - Outputs fine[4:0] and valid.
  - Separately unit-testable.

Test Plan:
- Reset then en=1 with ctr_freq_cfg=3'd5 -> tdc_ctr_freq=5; tdc_pd falls 1 cycle after en; tdc_pd_inj falls after 16 cycles; no tdc_valid before PRIME completes.
- RUN with coarse incrementing by 10 per clk and phase=16'h00FF, phase[0]=1 (fine=24) -> tdc_delta=12'd320 every cycle, tdc_word low 5 bits=24.
- Coarse steps 120→2 (wrap) with fine constant -> tdc_delta=12'd320.
- phase=16'h0F0F (t=4) for 4 consecutive cycles -> 4 bubble_err pulses, tdc_word held, state_o returns to PWRUP.
- en dropped while in INJ -> next cycle state_o=OFF, tdc_pd=1, tdc_pd_inj=1; rst_n pulsed in RUN -> all outputs at reset values immediately.
- TDC_CTRL_AVG_EN with AVG_LOG2=2 and deltas 300, 310, 320, 330 -> single tdc_valid with tdc_delta=315.
